// File: rtl/servo_ramp_controller.sv
// rtl/servo_ramp_controller.sv - two-channel 50 Hz servo PWM with per-frame slew-limited ramping (optional SERVO_ARRIVE_IRQ_EN)
module servo_ramp_controller #(
    parameter int TICK_DIV    = 50,
    parameter int FRAME_TICKS = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int CENTER_US   = 1500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [1:0]  servo_pwm,
    output logic [15:0] servo_pos_0,
    output logic [15:0] servo_pos_1
`ifdef SERVO_ARRIVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [15:0] MIN_V    = 16'(MIN_US);
    localparam logic [15:0] MAX_V    = 16'(MAX_US);
    localparam logic [15:0] CENTER_V = 16'(CENTER_US);

    typedef enum logic {ST_IDLE, ST_MOVING} ch_state_t;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   cur_q [2];
    logic [15:0]   cur_d [2];
    logic [15:0]   target_q [2];
    logic [15:0]   target_d [2];
    ch_state_t     state_q [2];
    ch_state_t     state_d [2];
    logic [15:0]   step_q, step_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [1:0]    run_q, run_d;
    logic [1:0]    pwm_q, pwm_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          boundary;
    logic          wr_step, wr_ctrl, wr_status;
    logic          arrive_set;
    logic          irq_en_rd, arrive_rd;
    logic [1:0]    moving;
    logic          unused_bits;

`ifdef SERVO_ARRIVE_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic arrive_q, arrive_d;
    assign irq_en_rd   = irq_en_q;
    assign arrive_rd   = arrive_q;
    assign irq         = arrive_q & irq_en_q;
    assign unused_bits = ^avs_writedata[31:16];
`else
    assign irq_en_rd   = 1'b0;
    assign arrive_rd   = 1'b0;
    assign unused_bits = ^{avs_writedata[31:16], arrive_set};
`endif

    function automatic logic [15:0] clamp_us(input logic [15:0] v);
        if (v < MIN_V) return MIN_V;
        if (v > MAX_V) return MAX_V;
        return v;
    endfunction

    // One frame's worth of movement: jump when STEP is 0 or the gap fits in one step
    function automatic logic [15:0] ramp(input logic [15:0] cur, input logic [15:0] tgt,
                                         input logic [15:0] stp);
        logic signed [16:0] diff;
        logic [16:0]        mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[16] ? $unsigned(-diff) : $unsigned(diff);
        if ((stp == 16'd0) || (mag <= {1'b0, stp})) return tgt;
        if (diff[16]) return cur - stp;
        return cur + stp;
    endfunction

    assign wr_step   = avs_write && (avs_address == 3'd2);
    assign wr_ctrl   = avs_write && (avs_address == 3'd3);
    assign wr_status = avs_write && (avs_address == 3'd4);
    assign moving    = {state_q[1] == ST_MOVING, state_q[0] == ST_MOVING};

    assign avs_readdata = rdata_q;
    assign servo_pwm    = pwm_q;
    assign servo_pos_0  = cur_q[0];
    assign servo_pos_1  = cur_q[1];

    // Next-state: timebase, register writes, frame-boundary ramp, channel FSMs, PWM and readback
    always_comb begin
        prescaler_d = prescaler_q;
        tick_d      = tick_q;
        cur_d       = cur_q;
        target_d    = target_q;
        state_d     = state_q;
        step_d      = step_q;
        ctrl_d      = ctrl_q;
        run_d       = run_q;
        pwm_d       = '0;
        rdata_d     = rdata_q;
        arrive_set  = 1'b0;

        boundary = (prescaler_q == '0) && (tick_q == '0);
        if (prescaler_q == PW'(TICK_DIV - 1)) begin
            prescaler_d = '0;
            tick_d      = (tick_q == TW'(FRAME_TICKS - 1)) ? '0 : tick_q + 1'b1;
        end else begin
            prescaler_d = prescaler_q + 1'b1;
        end

        if (wr_step) step_d = avs_writedata[15:0];
        if (wr_ctrl) ctrl_d = avs_writedata[1:0];

        for (int n = 0; n < 2; n++) begin
            logic        wr_tgt;
            logic        kill;
            logic [15:0] nxt;
            logic [15:0] tgt_new;
            wr_tgt  = avs_write && (avs_address == 3'(n));
            kill    = wr_ctrl && !avs_writedata[n];
            nxt     = ramp(cur_q[n], target_q[n], step_q);
            tgt_new = clamp_us(avs_writedata[15:0]);

            // Boundary sees the pre-write target/STEP because writes land in target_d only
            if (boundary && ctrl_q[n]) cur_d[n] = nxt;
            if (wr_tgt) target_d[n] = tgt_new;

            if (wr_tgt && (tgt_new != cur_q[n])) begin
                state_d[n] = ST_MOVING;
            end else if (boundary && ctrl_q[n] && (state_q[n] == ST_MOVING) && (nxt == target_q[n])) begin
                state_d[n] = ST_IDLE;
                arrive_set = 1'b1;
            end

            // A channel only drives pulses for frames it was enabled at the start of
            run_d[n] = (boundary ? ctrl_q[n] : run_q[n]) && !kill;
            pwm_d[n] = run_d[n] && (16'(tick_q) < cur_d[n]);
        end

        if (avs_read) begin
            case (avs_address)
                3'd0:    rdata_d = {16'd0, target_q[0]};
                3'd1:    rdata_d = {16'd0, target_q[1]};
                3'd2:    rdata_d = {16'd0, step_q};
                3'd3:    rdata_d = {29'd0, irq_en_rd, ctrl_q};
                3'd4:    rdata_d = {29'd0, arrive_rd, moving};
                default: rdata_d = 32'd0;
            endcase
        end
    end

`ifdef SERVO_ARRIVE_IRQ_EN
    // Arrive flag: software clear, boundary arrival wins a same-cycle clear
    always_comb begin
        irq_en_d = wr_ctrl ? avs_writedata[2] : irq_en_q;
        arrive_d = arrive_q;
        if (wr_status && avs_writedata[2]) arrive_d = 1'b0;
        if (arrive_set) arrive_d = 1'b1;
    end

    // Interrupt state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            arrive_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            arrive_q <= arrive_d;
        end
    end
`endif

    // Main state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            tick_q      <= '0;
            for (int n = 0; n < 2; n++) begin
                cur_q[n]    <= CENTER_V;
                target_q[n] <= CENTER_V;
                state_q[n]  <= ST_IDLE;
            end
            step_q  <= '0;
            ctrl_q  <= '0;
            run_q   <= '0;
            pwm_q   <= '0;
            rdata_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            tick_q      <= tick_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            state_q     <= state_d;
            step_q      <= step_d;
            ctrl_q      <= ctrl_d;
            run_q       <= run_d;
            pwm_q       <= pwm_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: doc/servo_ramp_controller.md
# servo_ramp_controller

Avalon-MM slave that owns the two hobby-servo outputs of the Computer_System and sequences them. Software writes a target position and a slew limit per frame; the block generates glitch-free 50 Hz PWM on both channels and ramps each pulse width toward its target by at most STEP µs per frame. The current ramped positions are exported as 16-bit buses for the LCD/debug datapath, matching the iservo_control export width.

## Interface
- TICK_DIV, 50: clk cycles per 1 µs tick (50 MHz clk).
- FRAME_TICKS, 20000: ticks per PWM frame (20 ms).
- MIN_US, 1000: minimum legal pulse width, µs.
- MAX_US, 2000: maximum legal pulse width, µs.
- CENTER_US, 1500: reset position, µs.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address.
- avs_write  in  1  write strobe, single cycle, no waitrequest.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- servo_pwm  out  2  PWM outputs, bit n = channel n.
- servo_pos_0  out  16  current (ramped) pulse width ch0, µs.
- servo_pos_1  out  16  current (ramped) pulse width ch1, µs.
- irq  out  1  only with SERVO_ARRIVE_IRQ_EN; otherwise absent.

## Operation
- Registers (word address): 0 TARGET0 [15:0] R/W; 1 TARGET1 [15:0] R/W; 2 STEP [15:0] R/W, max µs change per frame, 0 = jump immediately; 3 CTRL R/W, bit0 enable ch0, bit1 enable ch1, bit2 IRQ enable (macro only); 4 STATUS R, bit0/bit1 ch moving, bit2 arrive flag (macro only); writes to STATUS with bit2=1 clear arrive flag. Addresses 5–7 read 0, writes ignored. Unused read bits 0.
- TARGET writes clamped to [MIN_US, MAX_US] on capture; readback returns clamped value.
- Timebase: prescaler 0..TICK_DIV-1; tick counter 0..FRAME_TICKS-1, advances when prescaler wraps.
- Frame boundary = cycle where prescaler==0 and tick==0. At boundary, per channel with enable=1: diff = target − cur; if STEP==0 or |diff| ≤ STEP then cur ← target, else cur ← cur ± STEP. Disabled channel: cur frozen.
- Per-channel FSM: IDLE (cur==target) ↔ MOVING (cur≠target). IDLE→MOVING on TARGET write differing from cur; MOVING→IDLE at boundary where cur reaches target. STATUS moving bits reflect state.
- PWM: servo_pwm[n] = enable[n] && (tick < cur_n), using cur as updated at the last boundary. Disabled channel held low. servo_pos_n = cur_n.
- Arithmetic: 16-bit unsigned for cur/target/STEP; diff computed 17-bit signed; no overflow since values bounded by MAX_US.

## Timing
- Reset: TARGET0/1 = cur0/1 = CENTER_US, STEP=0, CTRL=0, arrive=0, servo_pwm=0, avs_readdata=0, irq=0, prescaler=tick=0, both FSMs IDLE.
- Register write takes effect the cycle after avs_write; pulse width changes only at the next frame boundary (no mid-frame truncation).
- Write coinciding with frame boundary: boundary update uses pre-write target/STEP; new value applies next boundary.
- Enable rising mid-frame: PWM stays low until next boundary. Enable falling: PWM low next cycle.
- avs_readdata registered, latency 1; holds last value when no read.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous).

## Configuration
- SERVO_ARRIVE_IRQ_EN defined: irq port, CTRL bit2 and STATUS bit2 exist. At a boundary where any enabled channel goes MOVING→IDLE, arrive ← 1; irq = arrive && CTRL[2]; cleared by STATUS write bit2=1 (set wins if same cycle as boundary).
- Undefined: no irq port, CTRL bit2 reads 0, STATUS bit2 reads 0, writes ignored.

## Test plan
- Reset, CTRL=3: each channel high exactly 1500×TICK_DIV cycles per 20000×TICK_DIV-cycle frame; servo_pos_0/1 = 1500.
- TARGET0=2000, STEP=100: servo_pos_0 steps 1600,1700,…,2000 on five successive boundaries; STATUS bit0 = 1 until 2000 then 0.
- TARGET1=500 → readback 1000; TARGET1=60000 → readback 2000; with STEP=0, cur1 jumps at next boundary.
- TARGET0 write on boundary cycle: cur0 unchanged that boundary, updates next.
- CTRL=0 mid-frame: servo_pwm=0 next cycle, servo_pos frozen despite pending target.
- With SERVO_ARRIVE_IRQ_EN, CTRL=7, TARGET0=1550, STEP=25: irq rises at second boundary; STATUS write 0x4 drops irq next cycle.
